mod_addsub_pipe: RTL and testbench

Pipelined modular adder/subtractor over Z_Q for the Kyber NTT datapath, the parametrised successor of the combinational 16-bit modular adder. It accepts one operand pair per cycle under a valid/ready handshake, performs either (a+b) mod Q or (a−b) mod Q, and returns results in order after a fixed two-stage pipeline with full backpressure. It carries a per-transaction tag and flags out-of-range operands. It sits between the coefficient memory read port and the butterfly/write-back logic.

---
 rtl/mod_addsub_pipe.sv | 102 ++++++++++
 tb/tb_mod_addsub_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor over Z_Q with valid/ready
// handshakes, a passthrough tag and an out-of-range operand flag.
module mod_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int Q     = 3329,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  // Handshake: a transfer happens on a port exactly in the cycle where its
  // valid and ready are both high at the rising edge. in_ready never looks at
  // in_valid, and out_valid stays high with stable data until out_ready.

  localparam logic [WIDTH:0]   Q_EXT = (WIDTH+1)'(Q);
  localparam logic [WIDTH-1:0] Q_W   = WIDTH'(Q);

  logic             r_s1_v;
  logic [WIDTH:0]   r_s1_raw;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_err;

  logic             r_s2_v;
  logic [WIDTH-1:0] r_s2_res;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_err;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_in_fire;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_raw;
  logic             w_err;
  logic [WIDTH:0]   w_red;

  assign w_s2_load = !r_s2_v || out_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign in_ready  = !r_s1_v || !r_s2_v || out_ready;
  assign w_in_fire = in_valid && in_ready;

  // Adding Q before subtracting keeps the in-range difference non-negative.
  assign w_a_ext = {1'b0, in_a};
  assign w_b_ext = {1'b0, in_b};
  assign w_raw   = in_sub ? (w_a_ext + Q_EXT - w_b_ext) : (w_a_ext + w_b_ext);
  assign w_err   = (in_a >= Q_W) || (in_b >= Q_W);

  // One conditional subtraction suffices because raw < 2Q for in-range operands.
  assign w_red = (r_s1_raw >= Q_EXT) ? (r_s1_raw - Q_EXT) : r_s1_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s1_raw <= '0;
      r_s1_tag <= '0;
      r_s1_err <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_v <= w_in_fire;
      if (w_in_fire) begin
        r_s1_raw <= w_raw;
        r_s1_tag <= in_tag;
        r_s1_err <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v   <= 1'b0;
      r_s2_res <= '0;
      r_s2_tag <= '0;
      r_s2_err <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_res <= w_red[WIDTH-1:0];
        r_s2_tag <= r_s1_tag;
        r_s2_err <= r_s1_err;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_res   = r_s2_res;
  assign out_tag   = r_s2_tag;
  assign out_err   = r_s2_err;
  assign busy      = r_s1_v | r_s2_v;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Bench for mod_addsub_pipe: directed and random transactions checked against
// a modular-arithmetic reference model through an in-order expected queue.
module tb_mod_addsub_pipe;

  localparam int WIDTH = 16;
  localparam int Q     = 3329;
  localparam int TAG_W = 8;
  localparam int EW    = 1 + TAG_W + WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_sub = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int out_count = 0;
  logic [EW-1:0] exp_q[$];

  mod_addsub_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // Reference: exact (a +/- b) mod Q in range; otherwise the raw formula truncated.
  function automatic logic [EW-1:0] model(input int unsigned a, input int unsigned b,
                                          input logic sub, input logic [TAG_W-1:0] tag);
    int unsigned raw;
    int unsigned res;
    logic err;
    err = (a >= Q) || (b >= Q);
    if (!err) begin
      res = sub ? ((a + Q - b) % Q) : ((a + b) % Q);
    end else begin
      raw = sub ? ((a + Q - b) & 32'h1ffff) : ((a + b) & 32'h1ffff);
      if (raw >= Q) raw = raw - Q;
      res = raw & 32'hffff;
    end
    return {err, tag, res[WIDTH-1:0]};
  endfunction

  // One clock: sample handshakes shortly after the inputs settle, score, then step.
  task automatic cycle(output logic acc);
    logic ox;
    logic [EW-1:0] e;
    #1;
    acc = in_valid && in_ready && !rst;
    ox  = out_valid && out_ready && !rst;
    if (ox) begin
      out_count++;
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_fields", {out_err, out_tag, out_res}, e);
      end
    end
    if (acc) exp_q.push_back(model(in_a, in_b, in_sub, in_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int unsigned a, input int unsigned b, input logic sub,
                        input logic [TAG_W-1:0] tag);
    in_a = WIDTH'(a); in_b = WIDTH'(b); in_sub = sub; in_tag = tag; in_valid = 1'b1;
  endtask

  // Single transaction from an empty pipe with out_ready high, checking latency.
  task automatic send(input string name, input int unsigned a, input int unsigned b,
                      input logic sub, input logic [TAG_W-1:0] tag,
                      input int unsigned exp_res, input logic exp_err);
    logic acc;
    out_ready = 1'b1;
    set_in(a, b, sub, tag);
    cycle(acc);
    chk({name, "_accept"}, acc, 1);
    in_valid = 1'b0;
    chk({name, "_lat1_valid"}, out_valid, 0);
    cycle(acc);
    chk({name, "_lat2_valid"}, out_valid, 1);
    chk({name, "_res"}, out_res, exp_res);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_err"}, out_err, exp_err);
    cycle(acc);
    chk({name, "_drained"}, busy, 0);
  endtask

  initial begin
    logic acc;
    int k;
    int base;
    logic [WIDTH-1:0] held;
    int unsigned bp_a[4];
    int unsigned bp_b[4];

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);

    send("add", 3000, 1000, 1'b0, 8'h11, 671, 1'b0);
    send("sub_wrap", 5, 10, 1'b1, 8'h22, 3324, 1'b0);
    send("add_max", 3328, 3328, 1'b0, 8'h33, 3327, 1'b0);
    send("sub_zero", 0, 0, 1'b1, 8'h44, 0, 1'b0);

    // Streaming: one accept and one result per cycle.
    base = out_count;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      set_in($urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
             1'($urandom_range(1, 0)), TAG_W'(i));
      #1;
      chk("stream_in_ready", in_ready, 1);
      if (i >= 2) chk("stream_out_valid", out_valid, 1);
      cycle(acc);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle(acc);
    chk("stream_count", out_count - base, 64);

    // Backpressure: only two of four offered pairs fit while out_ready is low.
    base = out_count;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = $urandom_range(Q - 1, 0);
      bp_b[i] = $urandom_range(Q - 1, 0);
    end
    k = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(bp_a[k], bp_b[k], 1'(i % 2), 8'hA0 + 8'(k));
      cycle(acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    held = out_res;
    cycle(acc);
    chk("bp_out_stable", out_res, held);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", in_ready, 1);
    for (int i = 0; i < 10 && k < 4; i++) begin
      set_in(bp_a[k], bp_b[k], 1'b0, 8'hA0 + 8'(k));
      cycle(acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", k, 4);
    in_valid = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle(acc);
    chk("bp_out_count", out_count - base, 4);

    send("oor", 4000, 1, 1'b0, 8'h55, 672, 1'b1);
    send("after_oor", 5, 6, 1'b0, 8'h56, 11, 1'b0);

    // Reset while the pipe is full and a pair is being offered.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(100 + i, 200, 1'b0, 8'h60 + 8'(i));
      cycle(acc);
    end
    chk("full_busy", busy, 1);
    rst = 1'b1;
    set_in(7, 8, 1'b0, 8'h70);
    cycle(acc);
    exp_q.delete();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_res", out_res, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    send("post_rst", 1, 2, 1'b0, 8'h77, 3, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
